// File: rtl/conv_sequencer.sv
// Job sequencer in front of the per-PE control FSM: accepts one convolution command,
// walks control through reset/load/ready/start_op and gates the weight stream during load.
module conv_sequencer #(
    parameter int N             = 3,
    parameter int NUM_COL_WIDTH = $clog2(N + 1),
    parameter int SEL_WIDTH     = $clog2(N),
    parameter int RUN_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [NUM_COL_WIDTH-1:0] cmd_column_num_i,
    input  logic [NUM_COL_WIDTH-1:0] cmd_row_num_i,
    input  logic [NUM_COL_WIDTH-1:0] cmd_filter_size_i,
    input  logic [SEL_WIDTH-1:0]     cmd_f_sel_i,
    input  logic [RUN_WIDTH-1:0]     cmd_run_len_i,
    input  logic                     wt_valid_i,
    output logic                     wt_ready_o,
    input  logic                     abort_i,
    output logic                     ctrl_rst_o,
    output logic                     ctrl_load_o,
    output logic                     ctrl_ready_o,
    output logic                     ctrl_start_op_o,
    output logic [NUM_COL_WIDTH-1:0] column_num_o,
    output logic [NUM_COL_WIDTH-1:0] row_num_o,
    output logic [NUM_COL_WIDTH-1:0] filter_size_o,
    output logic [SEL_WIDTH-1:0]     f_sel_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    localparam logic [NUM_COL_WIDTH-1:0] COL_ONE = NUM_COL_WIDTH'(1);
    localparam logic [NUM_COL_WIDTH-1:0] COL_MAX = NUM_COL_WIDTH'(N);
    localparam logic [RUN_WIDTH-1:0]     RUN_ONE = RUN_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NUM_COL_WIDTH-1:0] r_wt_cnt;
    logic [NUM_COL_WIDTH-1:0] w_wt_cnt_next;
    logic [RUN_WIDTH-1:0]     r_run_cnt;
    logic [RUN_WIDTH-1:0]     w_run_cnt_next;
    logic [RUN_WIDTH-1:0]     r_run_len;
    logic [NUM_COL_WIDTH-1:0] r_column_num;
    logic [NUM_COL_WIDTH-1:0] r_row_num;
    logic [NUM_COL_WIDTH-1:0] r_filter_size;
    logic [SEL_WIDTH-1:0]     r_f_sel;
    logic                     r_ctrl_rst;
    logic                     r_ctrl_load;
    logic                     r_ctrl_ready;
    logic                     r_ctrl_start_op;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic                     w_cmd_ok;
    logic                     w_latch;
    logic                     w_err_next;

    // A command is usable only if every geometry field is in 1..N and the run is non-empty.
    assign w_cmd_ok = (cmd_column_num_i  != '0) && (cmd_column_num_i  <= COL_MAX) &&
                      (cmd_row_num_i     != '0) && (cmd_row_num_i     <= COL_MAX) &&
                      (cmd_filter_size_i != '0) && (cmd_filter_size_i <= COL_MAX) &&
                      (cmd_run_len_i     != '0);

    always_comb begin
        w_state_next   = r_state;
        w_wt_cnt_next  = r_wt_cnt;
        w_run_cnt_next = r_run_cnt;
        w_latch        = 1'b0;
        w_err_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (w_cmd_ok) begin
                        w_latch       = 1'b1;
                        w_wt_cnt_next = '0;
                        w_state_next  = S_LOAD;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Abort wins over a simultaneous final weight handshake.
                if (abort_i) begin
                    w_state_next = S_IDLE;
                end else if (wt_valid_i) begin
                    w_wt_cnt_next = r_wt_cnt + COL_ONE;
                    if (r_wt_cnt == r_filter_size - COL_ONE) begin
                        w_state_next = S_READY;
                    end
                end
            end
            S_READY: begin
                if (abort_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_run_cnt_next = '0;
                    w_state_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_run_cnt_next = r_run_cnt + RUN_ONE;
                    if (r_run_cnt == r_run_len - RUN_ONE) begin
                        w_state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Control strobes are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state         <= S_IDLE;
            r_wt_cnt        <= '0;
            r_run_cnt       <= '0;
            r_run_len       <= '0;
            r_column_num    <= '0;
            r_row_num       <= '0;
            r_filter_size   <= '0;
            r_f_sel         <= '0;
            r_ctrl_rst      <= 1'b1;
            r_ctrl_load     <= 1'b0;
            r_ctrl_ready    <= 1'b0;
            r_ctrl_start_op <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_wt_cnt        <= w_wt_cnt_next;
            r_run_cnt       <= w_run_cnt_next;
            if (w_latch) begin
                r_column_num  <= cmd_column_num_i;
                r_row_num     <= cmd_row_num_i;
                r_filter_size <= cmd_filter_size_i;
                r_f_sel       <= cmd_f_sel_i;
                r_run_len     <= cmd_run_len_i;
            end
            r_ctrl_rst      <= (w_state_next == S_IDLE) || (w_state_next == S_FLUSH);
            r_ctrl_load     <= (w_state_next == S_LOAD);
            r_ctrl_ready    <= (w_state_next == S_READY);
            r_ctrl_start_op <= (w_state_next == S_RUN);
            r_busy          <= (w_state_next != S_IDLE);
            r_done          <= (w_state_next == S_FLUSH);
            r_err           <= w_err_next;
        end
    end

    assign cmd_ready_o     = (r_state == S_IDLE);
    assign wt_ready_o      = (r_state == S_LOAD);
    assign ctrl_rst_o      = r_ctrl_rst;
    assign ctrl_load_o     = r_ctrl_load;
    assign ctrl_ready_o    = r_ctrl_ready;
    assign ctrl_start_op_o = r_ctrl_start_op;
    assign column_num_o    = r_column_num;
    assign row_num_o       = r_row_num;
    assign filter_size_o   = r_filter_size;
    assign f_sel_o         = r_f_sel;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;

endmodule
